time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 10, giving the number of tick_in rising edges per second (range 2..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port tick_in, input, 1 bit: slow square wave from the divider, asynchronous to clk; one rising edge = one tenth-second.
REQ-005 The block SHALL have port run, input, 1 bit: 1 = count ticks; 0 = hold time.
REQ-006 The block SHALL have port load, input, 1 bit: one-cycle request to load load_hh/load_mm/load_ss.
REQ-007 The block SHALL have ports load_hh, load_mm, load_ss, input, 8 bits each: packed BCD (tens in [7:4], ones in [3:0]).
REQ-008 The block SHALL have ports hh, mm, ss, output, 8 bits each: current time, packed BCD, 24-hour format.
REQ-009 The block SHALL have port tenths, output, 4 bits: binary sub-second count, 0..TICKS_PER_SEC-1.
REQ-010 The block SHALL have port sec_pulse, output, 1 bit: one-cycle strobe when tenths wraps to 0.
REQ-011 The block SHALL have port day_wrap, output, 1 bit: one-cycle strobe on the 23:59:59 -> 00:00:00 wrap.
REQ-012 The block SHALL have port load_err, output, 1 bit: one-cycle strobe when a load is rejected.

Function
REQ-013 tick_in SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3; edge = s2 AND NOT s3.
REQ-014 Counters SHALL advance on the third rising clk edge after the first edge that samples tick_in high; latency is fixed at 3 cycles.
REQ-015 Falling edges of tick_in SHALL have no effect; one rising edge SHALL cause exactly one increment.
REQ-016 When edge=1 and run=0, the edge SHALL be discarded, not queued.
REQ-017 Each counted edge SHALL increment tenths; at TICKS_PER_SEC-1 it SHALL wrap to 0 and carry into ss.
REQ-018 The ss and mm counters SHALL run 00..59, incrementing ones 0..9 and carrying to tens 0..5, and SHALL carry upward on a 59 -> 00 wrap.
REQ-019 The hh counter SHALL run 00..23 and SHALL wrap 23 -> 00 with no further carry.
REQ-020 sec_pulse SHALL be registered and high for exactly the cycle in which the new tenths=0 value is first visible.
REQ-021 day_wrap SHALL be registered and high for exactly the cycle in which 00:00:00.0 is first visible after a wrap from 23:59:59.(TICKS_PER_SEC-1).
REQ-022 A load is valid only if every BCD digit is <=9, load_hh <= 0x23, load_mm <= 0x59 and load_ss <= 0x59.
REQ-023 A valid load SHALL update hh/mm/ss one cycle later and SHALL clear tenths to 0; it SHALL NOT assert sec_pulse or day_wrap.
REQ-024 An invalid load SHALL leave all time state unchanged and SHALL assert load_err for one cycle, one cycle after load.
REQ-025 load SHALL be honoured regardless of run.
REQ-026 If load and edge occur in the same cycle, load SHALL win and the edge SHALL be discarded.
REQ-027 The synchronizer flops SHALL keep running during a load.
REQ-028 Outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-029 When clr=1 at a clk edge, the block SHALL set hh=mm=ss=0x00 and tenths=0, and SHALL clear sec_pulse, day_wrap and load_err.
REQ-030 While clr=1, the block SHALL set s1=s2=s3=0.
REQ-031 clr SHALL take priority over load and edge.
REQ-032 Asserting clr mid-count SHALL abort any pending carry.
REQ-033 If tick_in is high when clr deasserts, a single edge SHALL be detected after the synchronizer fills; this edge SHALL be counted when run=1.

Verification
REQ-034 The bench SHALL cover: clr, run=1, 10 tick_in rising edges (TICKS_PER_SEC=10) -> ss=0x01, tenths=0, sec_pulse exactly once, 3 cycles after the 10th rising edge.
REQ-035 The bench SHALL cover: load 23:59:59 then 10 edges -> hh/mm/ss=0x00/0x00/0x00 and day_wrap high for 1 cycle coincident with sec_pulse.
REQ-036 The bench SHALL cover: load_hh=0x24 and, separately, load_mm=0x5A -> load_err pulses, time unchanged.
REQ-037 The bench SHALL cover: run=0 with 5 edges, then run=1 -> tenths unchanged through the pause; only edges arriving after run=1 are counted.
REQ-038 The bench SHALL cover: load 12:34:56 asserted in the same cycle as an edge -> time=12:34:56.0, edge lost, no sec_pulse.
REQ-039 The bench SHALL cover: clr asserted at 09:59:59.9 together with an edge -> all outputs 0, no day_wrap/sec_pulse.

Source files
------------

// File: rtl/time_keeper.sv
// Real-time clock. Counts synchronized tick_in rising edges into tenths and a
// packed-BCD 24-hour hh:mm:ss. Loads are checked for validity before they are applied.
module time_keeper #(
    parameter int unsigned TICKS_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic [3:0] tenths,
    output logic       sec_pulse,
    output logic       day_wrap,
    output logic       load_err
);
    localparam int unsigned BCD_W = 8;
    localparam int unsigned SUB_W = 4;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Both digits must be decimal before the packed compare against the limit is meaningful.
    function automatic logic bcd_ok(input logic [BCD_W-1:0] v, input logic [BCD_W-1:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    logic             s1;
    logic             s2;
    logic             s3;
    logic             tick_edge_c;
    logic             load_ok_c;
    logic             tenths_wrap_c;
    logic             ss_wrap_c;
    logic             mm_wrap_c;
    logic             hh_wrap_c;
    logic [BCD_W-1:0] hh_nxt;
    logic [BCD_W-1:0] mm_nxt;
    logic [BCD_W-1:0] ss_nxt;
    logic [SUB_W-1:0] tenths_nxt;
    logic             sec_pulse_nxt;
    logic             day_wrap_nxt;
    logic             load_err_nxt;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick_edge_c   = s2 & ~s3;
    assign load_ok_c     = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59) &&
                           bcd_ok(load_ss, 8'h59);
    assign tenths_wrap_c = (tenths == SUB_MAX);
    assign ss_wrap_c     = (ss == 8'h59);
    assign mm_wrap_c     = (mm == 8'h59);
    assign hh_wrap_c     = (hh == 8'h23);

    // Next time value. A load always takes precedence and swallows a coincident edge.
    always_comb begin
        hh_nxt        = hh;
        mm_nxt        = mm;
        ss_nxt        = ss;
        tenths_nxt    = tenths;
        sec_pulse_nxt = 1'b0;
        day_wrap_nxt  = 1'b0;
        load_err_nxt  = 1'b0;
        if (load) begin
            if (load_ok_c) begin
                hh_nxt     = load_hh;
                mm_nxt     = load_mm;
                ss_nxt     = load_ss;
                tenths_nxt = '0;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (tick_edge_c && run) begin
            if (tenths_wrap_c) begin
                tenths_nxt    = '0;
                sec_pulse_nxt = 1'b1;
                ss_nxt        = ss_wrap_c ? 8'h00 : bcd_inc(ss);
                if (ss_wrap_c) begin
                    mm_nxt = mm_wrap_c ? 8'h00 : bcd_inc(mm);
                    if (mm_wrap_c) begin
                        hh_nxt       = hh_wrap_c ? 8'h00 : bcd_inc(hh);
                        day_wrap_nxt = hh_wrap_c;
                    end
                end
            end else begin
                tenths_nxt = tenths + 4'd1;
            end
        end
    end

    // Time and strobe registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            hh        <= '0;
            mm        <= '0;
            ss        <= '0;
            tenths    <= '0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            hh        <= hh_nxt;
            mm        <= mm_nxt;
            ss        <= ss_nxt;
            tenths    <= tenths_nxt;
            sec_pulse <= sec_pulse_nxt;
            day_wrap  <= day_wrap_nxt;
            load_err  <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: a load-validation vector table, directed corner-case sequences
// and random traffic, all checked against a model that counts time in total tenths.
module tb_time_keeper;
    localparam int TPS = 10;
    localparam int DAY = 86400 * TPS;

    logic       clk;
    logic       clr;
    logic       tick_in;
    logic       run;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [3:0] tenths;
    logic       sec_pulse;
    logic       day_wrap;
    logic       load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int sp_seen = 0;
    int dw_seen = 0;

    // Model state: time as a total count of tenths since midnight.
    int m_t = 0;
    bit m_sp = 0;
    bit m_dw = 0;
    bit m_le = 0;
    bit m_prev = 0;
    bit m_valid = 0;
    int m_cyc = 0;
    int m_pend[$];

    typedef struct {
        logic [7:0] lhh;
        logic [7:0] lmm;
        logic [7:0] lss;
        logic       err;
        logic [7:0] ehh;
        logic [7:0] emm;
        logic [7:0] ess;
    } ld_vec_t;

    ld_vec_t vecs[12];

    time_keeper #(.TICKS_PER_SEC(TPS)) dut (
        .clk      (clk),
        .clr      (clr),
        .tick_in  (tick_in),
        .run      (run),
        .load     (load),
        .load_hh  (load_hh),
        .load_mm  (load_mm),
        .load_ss  (load_ss),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .tenths   (tenths),
        .sec_pulse(sec_pulse),
        .day_wrap (day_wrap),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int bcd_val(input logic [7:0] b);
        return (int'(b[7:4]) * 10) + int'(b[3:0]);
    endfunction

    function automatic bit field_ok(input logic [7:0] b, input int lim);
        return (int'(b[7:4]) <= 9) && (int'(b[3:0]) <= 9) && (bcd_val(b) <= lim);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A rise sampled at clock edge n is applied at edge n+2; clr drops anything in flight.
    task automatic model_step();
        bit fire;
        if (clr) begin
            m_valid = 1'b1;
            m_t     = 0;
            m_sp    = 1'b0;
            m_dw    = 1'b0;
            m_le    = 1'b0;
            m_prev  = 1'b0;
            m_pend.delete();
        end else begin
            m_sp = 1'b0;
            m_dw = 1'b0;
            m_le = 1'b0;
            fire = 1'b0;
            if (m_pend.size() > 0 && m_pend[0] == m_cyc) begin
                fire = 1'b1;
                void'(m_pend.pop_front());
            end
            if (tick_in && !m_prev) m_pend.push_back(m_cyc + 2);
            m_prev = tick_in;
            if (load) begin
                if (field_ok(load_hh, 23) && field_ok(load_mm, 59) && field_ok(load_ss, 59))
                    m_t = ((bcd_val(load_hh) * 60 + bcd_val(load_mm)) * 60 + bcd_val(load_ss)) * TPS;
                else
                    m_le = 1'b1;
            end else if (fire && run) begin
                m_t  = (m_t + 1) % DAY;
                m_sp = (m_t % TPS) == 0;
                m_dw = (m_t == 0);
            end
        end
        m_cyc++;
    endtask

    task automatic cyc();
        int secs;
        @(posedge clk);
        model_step();
        #1;
        if (sec_pulse === 1'b1) sp_seen++;
        if (day_wrap === 1'b1) dw_seen++;
        if (m_valid) begin
            secs = m_t / TPS;
            chk("model_hh", 32'(hh), 32'(to_bcd(secs / 3600)));
            chk("model_mm", 32'(mm), 32'(to_bcd((secs / 60) % 60)));
            chk("model_ss", 32'(ss), 32'(to_bcd(secs % 60)));
            chk("model_tenths", 32'(tenths), 32'(m_t % TPS));
            chk("model_sec_pulse", 32'(sec_pulse), 32'(m_sp));
            chk("model_day_wrap", 32'(day_wrap), 32'(m_dw));
            chk("model_load_err", 32'(load_err), 32'(m_le));
        end
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            repeat (hi) cyc();
            tick_in = 1'b0;
            repeat (lo) cyc();
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load    = 1'b1;
        load_hh = h;
        load_mm = m;
        load_ss = s;
        cyc();
        load    = 1'b0;
    endtask

    initial begin
        int r;
        clr = 1'b1; tick_in = 1'b0; run = 1'b0; load = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;

        vecs[0]  = '{8'h12, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00};
        vecs[1]  = '{8'h24, 8'h00, 8'h00, 1'b1, 8'h12, 8'h00, 8'h00};
        vecs[2]  = '{8'h12, 8'h5A, 8'h00, 1'b1, 8'h12, 8'h00, 8'h00};
        vecs[3]  = '{8'h23, 8'h59, 8'h59, 1'b0, 8'h23, 8'h59, 8'h59};
        vecs[4]  = '{8'h1A, 8'h00, 8'h00, 1'b1, 8'h23, 8'h59, 8'h59};
        vecs[5]  = '{8'h00, 8'h60, 8'h00, 1'b1, 8'h23, 8'h59, 8'h59};
        vecs[6]  = '{8'h00, 8'h00, 8'h60, 1'b1, 8'h23, 8'h59, 8'h59};
        vecs[7]  = '{8'h20, 8'h09, 8'h45, 1'b0, 8'h20, 8'h09, 8'h45};
        vecs[8]  = '{8'hF0, 8'h00, 8'h00, 1'b1, 8'h20, 8'h09, 8'h45};
        vecs[9]  = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{8'h05, 8'h0F, 8'h30, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{8'h19, 8'h45, 8'h09, 1'b0, 8'h19, 8'h45, 8'h09};

        // Reset state
        repeat (2) cyc();
        chk("rst_hh", 32'(hh), 32'h0);
        chk("rst_tenths", 32'(tenths), 32'h0);
        chk("rst_strobes", 32'({sec_pulse, day_wrap, load_err}), 32'h0);
        clr = 1'b0;

        // Ten edges roll one second; sec_pulse lands on the third clock after the tenth rise
        run = 1'b1;
        sp_seen = 0;
        pulses(9, 2, 2);
        chk("s1_tenths9", 32'(tenths), 32'd9);
        chk("s1_no_sp_yet", 32'(sp_seen), 32'd0);
        tick_in = 1'b1;
        cyc(); chk("s1_sp_e1", 32'(sec_pulse), 32'd0);
        cyc(); chk("s1_sp_e2", 32'(sec_pulse), 32'd0);
        cyc();
        chk("s1_sp_e3", 32'(sec_pulse), 32'd1);
        chk("s1_ss", 32'(ss), 32'h01);
        chk("s1_tenths0", 32'(tenths), 32'd0);
        tick_in = 1'b0;
        repeat (4) cyc();
        chk("s1_sp_once", 32'(sp_seen), 32'd1);

        // Day wrap from 23:59:59
        do_load(8'h23, 8'h59, 8'h59);
        chk("s2_load_hh", 32'(hh), 32'h23);
        sp_seen = 0; dw_seen = 0;
        pulses(9, 2, 2);
        tick_in = 1'b1;
        cyc(); cyc();
        chk("s2_dw_early", 32'(day_wrap), 32'd0);
        cyc();
        chk("s2_dw", 32'(day_wrap), 32'd1);
        chk("s2_sp", 32'(sec_pulse), 32'd1);
        chk("s2_time", 32'({hh, mm, ss}), 32'h0);
        cyc();
        chk("s2_dw_drop", 32'(day_wrap), 32'd0);
        tick_in = 1'b0;
        repeat (3) cyc();
        chk("s2_dw_once", 32'(dw_seen), 32'd1);

        // Load validation table
        run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].lhh, vecs[i].lmm, vecs[i].lss);
            chk($sformatf("tbl%0d_err", i), 32'(load_err), 32'(vecs[i].err));
            chk($sformatf("tbl%0d_time", i), 32'({hh, mm, ss}),
                32'({vecs[i].ehh, vecs[i].emm, vecs[i].ess}));
            chk($sformatf("tbl%0d_tenths", i), 32'(tenths), 32'd0);
            cyc();
            chk($sformatf("tbl%0d_err_drop", i), 32'(load_err), 32'd0);
        end

        // Pause: edges during run=0 are discarded, not queued
        run = 1'b1;
        do_load(8'h00, 8'h00, 8'h00);
        pulses(3, 2, 2);
        chk("s4_pre", 32'(tenths), 32'd3);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulses(1, 2, 2);
            chk($sformatf("s4_pause%0d", i), 32'(tenths), 32'd3);
        end
        run = 1'b1;
        repeat (3) cyc();
        chk("s4_resume_idle", 32'(tenths), 32'd3);
        pulses(2, 2, 2);
        chk("s4_after", 32'(tenths), 32'd5);

        // Load coincident with a counted edge at tenths=9
        do_load(8'h00, 8'h00, 8'h00);
        pulses(9, 2, 2);
        chk("s5_pre", 32'(tenths), 32'd9);
        sp_seen = 0;
        tick_in = 1'b1;
        cyc(); cyc();
        do_load(8'h12, 8'h34, 8'h56);
        chk("s5_time", 32'({hh, mm, ss}), 32'h123456);
        chk("s5_tenths", 32'(tenths), 32'd0);
        tick_in = 1'b0;
        repeat (4) cyc();
        chk("s5_edge_lost", 32'(tenths), 32'd0);
        chk("s5_no_sp", 32'(sp_seen), 32'd0);

        // clr with a pending carry at 09:59:59.9, tick_in still high afterwards
        do_load(8'h09, 8'h59, 8'h59);
        pulses(9, 2, 2);
        sp_seen = 0; dw_seen = 0;
        tick_in = 1'b1;
        cyc(); cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("s6_time", 32'({hh, mm, ss}), 32'h0);
        chk("s6_tenths", 32'(tenths), 32'd0);
        chk("s6_strobes", 32'({sec_pulse, day_wrap, load_err}), 32'h0);
        cyc(); cyc();
        chk("s6_fill", 32'(tenths), 32'd0);
        cyc();
        chk("s6_post_clr_edge", 32'(tenths), 32'd1);
        chk("s6_no_strobes", 32'(sp_seen + dw_seen), 32'd0);
        tick_in = 1'b0;
        repeat (4) cyc();
        chk("s6_single_edge", 32'(tenths), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 8000; i++) begin
            r = int'($urandom_range(0, 999));
            clr  = (r < 2);
            load = (r >= 2 && r < 7);
            if (load) begin
                if ($urandom_range(0, 3) == 0) begin
                    load_hh = 8'($urandom);
                    load_mm = 8'($urandom);
                    load_ss = 8'($urandom);
                end else begin
                    load_hh = to_bcd(int'($urandom_range(20, 23)));
                    load_mm = to_bcd(int'($urandom_range(57, 59)));
                    load_ss = to_bcd(int'($urandom_range(50, 59)));
                end
            end
            if ($urandom_range(0, 9) < 5) tick_in = ~tick_in;
            run = ($urandom_range(0, 9) != 0);
            cyc();
        end
        clr = 1'b0; load = 1'b0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
